// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port, occupancy flags and optional sticky error flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to enable overflow/underflow tracking; otherwise both outputs read 0.
module sync_fifo #(
  parameter int DATA     = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                     system_clock,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [DATA-1:0]          wr_data,
  input  logic                     rd_en,
  output logic [DATA-1:0]          rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     err_clr,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a write is taken when wr_en && !full, a read when rd_en && !empty,
  // both judged on the flags registered before the edge; rejected requests are dropped.
  logic [DATA-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            wr_ok;
  logic            rd_ok;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AF_LEVEL));

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Storage carries no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge system_clock) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  // A fresh error wins over a clear arriving in the same cycle.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule
